instr_prefetch_unit: RTL

- Fetch stage placed directly upstream of the decode/execute instruction register.
- Generates sequential fetch addresses and issues requests to an instruction memory that has variable latency and returns responses in order.
- Buffers returned instructions, each with its PC, in a small FIFO.
- On a taken branch or jump redirect from execute, flushes the FIFO and discards all in-flight responses, so decode only ever sees correct-path instructions.

---
 rtl/instr_prefetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_unit.sv
// -----------------------------------------------------------------------------
// instr_prefetch_unit
//
// Fetch stage sitting directly in front of the decode/execute instruction
// register. It walks fetch_pc sequentially, issues requests to an in-order,
// variable-latency instruction memory, and buffers returned words together
// with their PCs in a DEPTH-entry FIFO. A redirect from execute flushes the
// FIFO and marks every outstanding response as stale, so decode only ever
// sees correct-path instructions.
//
// Handshakes (strict valid/ready): a transfer happens on a rising edge where
// valid && ready are both high. valid never depends on ready on the same
// interface. imem_rsp_valid has no ready; the unit always accepts a response.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned fetch address (fetch_pc)
//   imem_rsp_valid    response valid (responses return in request order)
//   imem_rsp_data     returned instruction word
//   redirect          taken branch / jump from execute
//   redirect_addr     redirect target (low two bits ignored)
//   instr_valid       FIFO head valid
//   instr_ready       decode consumes the head this cycle
//   instr_out         head instruction, NOP_INSTR when empty
//   pc_out            head PC, 0 when empty
// -----------------------------------------------------------------------------
module instr_prefetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;              // counters span 0..DEPTH
    localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [CW-1:0] count;

    // PCs of accepted requests, in issue order; popped by every response,
    // stale or not, so the head always tags the response currently arriving.
    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;

    // Per-cycle decisions
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] rsp_dec;

    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
        // Credit covers FIFO slots owed to live responses; the inflight bound
        // keeps the tag queue from overrunning while stale responses drain.
        imem_req_valid = !reset && !redirect
                         && (credit_used < {1'b0, DEPTH_N})
                         && (inflight < DEPTH_N);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_dec        = CW'(imem_rsp_valid);
        push           = imem_rsp_valid && (drop == '0) && !redirect;
        instr_valid    = (count != '0);
        pop            = instr_valid && instr_ready && !redirect;
        instr_out      = instr_valid ? fifo_instr[fifo_rd] : NOP_INSTR;
        pc_out         = instr_valid ? fifo_pc[fifo_rd]    : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            inflight <= '0;
            drop     <= '0;
        end else begin
            if (redirect) begin
                // Everything still outstanding after this edge belongs to
                // the wrong path; the response arriving now is discarded too.
                fetch_pc <= {redirect_addr[31:2], 2'b00};
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                count    <= '0;
                inflight <= inflight - rsp_dec;
                drop     <= inflight - rsp_dec;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    fifo_wr <= fifo_wr + PW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PW'(1);
                end
                count    <= count + CW'(push) - CW'(pop);
                inflight <= inflight + CW'(req_fire) - rsp_dec;
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
            if (req_fire) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + PW'(1);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[fifo_wr]    <= tag_q[tag_rd];
            fifo_instr[fifo_wr] <= imem_rsp_data;
        end
        if (req_fire) begin
            tag_q[tag_wr] <= fetch_pc;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    push_while_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == DEPTH_N)));

endmodule
